lifo: RTL and testbench
=======================

Name: lifo

Overview:
Synchronous last-in-first-out stack: 8-bit words, 16 entries, single clock domain. Sits between a producer and a consumer that need reverse-order retrieval, such as scratch buffering or nested-context save/restore. Provides registered read data and combinational full/empty status flags.

Parameters:
- DATA_WIDTH, 8, width of each stored word and of datain/dataout
- DEPTH, 16, number of entries (power of two, >= 2)
- PTR_WIDTH, $clog2(DEPTH)+1 (= 5), width of the stack-pointer/occupancy count (derived; not overridden)

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- we  input  1  push request
- re  input  1  pop request
- datain  input  DATA_WIDTH  word to push
- dataout  output  DATA_WIDTH  registered popped word
- full  output  1  high when occupancy == DEPTH
- empty  output  1  high when occupancy == 0

Behaviour:
- Interface rule: one clock (clk); reset is asynchronous and active-high.
- State:
  - storage array mem[0..DEPTH-1]
  - stack pointer sp (PTR_WIDTH bits, 0..DEPTH) = occupancy; the next free slot is mem[sp].
- Reset (asserted at any time, takes effect immediately):
  - sp=0, dataout=0, so empty=1 and full=0.
  - mem contents are not cleared.
  - Any in-flight operation is discarded.
- Flags: full=(sp==DEPTH) and empty=(sp==0), decoded combinationally from sp, so they update in the same cycle sp changes.
- Push only (we=1, re=0, full=0): mem[sp]<=datain; sp<=sp+1.
- Push when full: ignored. sp, mem and dataout are unchanged; no wrap-around.
- Pop only (re=1, we=0, empty=0): dataout<=mem[sp-1]; sp<=sp-1. Data is visible on dataout one clock after the sampling edge.
- Pop when empty: ignored. dataout holds its last value; sp stays 0; no underflow.
- we=1 and re=1, not empty:
  - Replace-top: dataout<=mem[sp-1]; mem[sp-1]<=datain; sp unchanged.
  - This applies even when full.
- we=1 and re=1, empty: treated as push only; dataout holds.
- Idle (we=0, re=0): everything holds; dataout keeps the last popped value.
- Held requests act on every clock edge. Holding re drains one entry per cycle until empty, then dataout freezes on the bottom-most entry.
- Only sp, dataout and mem are sequential; there are no other pipeline stages.

Decomposition:
- Package lifo_pkg holds the DATA_WIDTH/DEPTH defaults and the derived PTR_WIDTH constant.
- One natural sub-module, lifo_mem:
  - a DEPTH x DATA_WIDTH register array
  - one synchronous write port
  - one asynchronous read port addressed by sp-1
- Top level lifo owns the sp counter, the flags, the request decode (push/pop/replace/ignore) and the dataout register.

Test Plan:
- Reset: assert reset mid-clock with sp=5 -> sp=0, empty=1, full=0 and dataout=0 immediately, without waiting for a clock edge.
- Fill: push 16 random bytes on consecutive cycles -> empty falls after the 1st push, full rises after the 16th; a 17th push of 0xAA is ignored and full stays 1.
- Drain order: after the fill, hold re for 20 cycles.
  - dataout returns the bytes in reverse order, one per cycle, each one cycle after its edge.
  - empty rises with the last pop; dataout then holds the first-pushed byte.
- Underflow: on an empty stack, pulse re -> dataout unchanged, sp stays 0, empty stays 1.
- Replace-top: push 0x11 then 0x22; assert we=re=1 with datain=0x33 -> dataout=0x22, occupancy stays 2. Pop twice -> 0x33, then 0x11.
- Simultaneous on empty: we=re=1 with datain=0x5C on an empty stack -> occupancy 1, dataout unchanged; a following pop yields 0x5C.

Source files
------------

// File: rtl/lifo_pkg.sv
// lifo_pkg: default geometry shared by the stack and its storage
package lifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_PTR_WIDTH = $clog2(DEF_DEPTH) + 1;
endpackage

// File: rtl/lifo_mem.sv
// lifo_mem: register array with one synchronous write port and one asynchronous read port
module lifo_mem import lifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/lifo.sv
// lifo: 16x8 stack with registered pop data, replace-top on simultaneous push/pop, and occupancy flags
module lifo import lifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  full,
  output logic                  empty
);
  localparam int PTR_WIDTH = $clog2(DEPTH) + 1;
  localparam int AW = PTR_WIDTH - 1;
  logic [PTR_WIDTH-1:0] sp;
  logic [AW-1:0] top_addr, waddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic push, pop, rep, wen;
  assign full = sp == PTR_WIDTH'(DEPTH);
  assign empty = sp == '0;
  // simultaneous request on an empty stack degrades to a plain push
  assign push = we & ~full & (~re | empty);
  assign pop = re & ~we & ~empty;
  assign rep = we & re & ~empty;
  assign top_addr = sp[AW-1:0] - AW'(1);
  assign waddr = rep ? top_addr : sp[AW-1:0];
  assign wen = (push | rep) & ~reset;
  lifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) u_mem (
    .clk(clk),
    .we(wen),
    .waddr(waddr),
    .wdata(datain),
    .raddr(top_addr),
    .rdata(rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sp <= '0;
      dataout <= '0;
    end else begin
      if (push) sp <= sp + PTR_WIDTH'(1);
      else if (pop) sp <= sp - PTR_WIDTH'(1);
      if (pop | rep) dataout <= rdata;
    end
endmodule

// File: tb/tb_lifo.sv
// tb_lifo: directed vectors for the lifo stack with hand-computed expectations
module tb_lifo;
  logic clk, reset, we, re, full, empty;
  logic [7:0] datain, dataout;
  logic [7:0] pushed [16];
  int vectors = 0, miscompares = 0;
  lifo dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .re(re),
    .datain(datain),
    .dataout(dataout),
    .full(full),
    .empty(empty)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    we = w;
    re = r;
    datain = d;
    tick();
  endtask
  initial begin
    reset = 1;
    we = 0;
    re = 0;
    datain = 0;
    tick();
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_dout", dataout, 0);
    reset = 0;
    for (int i = 0; i < 6; i++) drive(1, 0, 8'(8'h40 + i));
    drive(0, 1, 0);
    check("pre_reset_dout", dataout, 8'h45);
    we = 0;
    re = 0;
    #2 reset = 1;
    #1;
    check("async_empty", empty, 1);
    check("async_full", full, 0);
    check("async_dout", dataout, 0);
    tick();
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      pushed[i] = 8'($urandom);
      drive(1, 0, pushed[i]);
      if (i == 0) check("fill_empty_falls", empty, 0);
      check($sformatf("fill_full_%0d", i), full, i == 15);
    end
    drive(1, 0, 8'hAA);
    check("overflow_full", full, 1);
    check("overflow_dout", dataout, 0);
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 0);
      check($sformatf("drain_dout_%0d", k), dataout, pushed[k < 16 ? 15 - k : 0]);
      check($sformatf("drain_empty_%0d", k), empty, k >= 15);
      check($sformatf("drain_full_%0d", k), full, 0);
    end
    drive(0, 1, 0);
    check("underflow_dout", dataout, pushed[0]);
    check("underflow_empty", empty, 1);
    drive(0, 0, 0);
    drive(1, 0, 8'h11);
    drive(1, 0, 8'h22);
    drive(1, 1, 8'h33);
    check("replace_dout", dataout, 8'h22);
    check("replace_empty", empty, 0);
    drive(0, 1, 0);
    check("replace_pop1", dataout, 8'h33);
    check("replace_pop1_empty", empty, 0);
    drive(0, 1, 0);
    check("replace_pop2", dataout, 8'h11);
    check("replace_pop2_empty", empty, 1);
    drive(1, 1, 8'h5C);
    check("simul_empty_dout", dataout, 8'h11);
    check("simul_empty_flag", empty, 0);
    drive(0, 1, 0);
    check("simul_pop", dataout, 8'h5C);
    check("simul_pop_empty", empty, 1);
    for (int i = 0; i < 16; i++) drive(1, 0, 8'(i));
    drive(1, 1, 8'hE7);
    check("replace_full_dout", dataout, 8'h0F);
    check("replace_full_flag", full, 1);
    drive(0, 1, 0);
    check("replace_full_pop", dataout, 8'hE7);
    check("replace_full_after", full, 0);
    drive(0, 0, 0);
    check("idle_hold", dataout, 8'hE7);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
